// File: rtl/data_ram_wait_pkg.sv
// data_ram_wait_pkg: shared FSM encodings and wait-counter width for data_ram_wait.
package data_ram_wait_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;
  localparam int CNT_W = 4;
endpackage

// File: rtl/data_ram_lane.sv
// data_ram_lane: one byte-wide memory lane with write enable and a registered read port.
module data_ram_lane #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic                  clr_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [7:0]            d_i,
  output logic [7:0]            q_o
);
  logic [7:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [7:0] q_q;
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= d_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else if (clr_i) q_q <= '0;
    else if (re_i) q_q <= mem[addr_i];
  end
  assign q_o = q_q;
endmodule

// File: rtl/data_ram_wait.sv
// data_ram_wait: byte-lane data RAM with req/ack handshake, programmable wait states
// and misaligned-access flagging.
module data_ram_wait
  import data_ram_wait_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] sel,
  input  logic [DATA_W-1:0]   data_i,
  output logic                ack,
  output logic                err,
  output logic                busy,
  output logic [DATA_W-1:0]   data_o
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam bit ZW = WAIT_CYCLES == 0;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, err_q;
  logic [ADDR_W-1:0]     addr_q, a_addr;
  logic [NB-1:0]         sel_q, a_sel;
  logic [DATA_W-1:0]     wd_q, a_wd;
  logic                  accept, fire, a_we, a_mis, unused_addr;
  logic [DEPTH_LOG2-1:0] widx;
  assign accept = req && (state_q == S_IDLE || state_q == S_RESP);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = ZW ? S_RESP : S_WAIT;
      cnt_d   = CNT_W'(WAIT_CYCLES);
    end else if (state_q == S_WAIT) begin
      state_d = (cnt_q == CNT_W'(1)) ? S_RESP : S_WAIT;
      cnt_d   = cnt_q - 1'b1;
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end
  end
  always_comb begin
    ack  = state_q == S_RESP;
    busy = state_q != S_IDLE;
    err  = ack & err_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      sel_q  <= '0;
      wd_q   <= '0;
    end else if (accept) begin
      we_q   <= we;
      addr_q <= addr;
      sel_q  <= sel;
      wd_q   <= data_i;
    end
  end
  // With no wait states acceptance and completion share an edge, so the live inputs are used.
  assign a_we        = ZW ? we : we_q;
  assign a_addr      = ZW ? addr : addr_q;
  assign a_sel       = ZW ? sel : sel_q;
  assign a_wd        = ZW ? data_i : wd_q;
  assign fire        = rst && state_d == S_RESP;
  assign a_mis       = |(a_addr & ADDR_W'(NB - 1));
  assign widx        = a_addr[DEPTH_LOG2+OB-1:OB];
  assign unused_addr = ^a_addr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (fire) err_q <= a_mis;
  end
  for (genvar i = 0; i < NB; i++) begin : g_lane
    data_ram_lane #(.DEPTH_LOG2(DEPTH_LOG2)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .we_i   (fire && a_we && !a_mis && a_sel[i]),
      .re_i   (fire && !a_we && !a_mis),
      .clr_i  (fire && a_mis),
      .addr_i (widx),
      .d_i    (a_wd[8*i +: 8]),
      .q_o    (data_o[8*i +: 8])
    );
  end
endmodule
